// File: rtl/forward_transform_4x4.sv
// Serialised 4x4 H.264 forward integer core transform (Y = Cf*X*Cf^T).
// One shared 1-D butterfly runs four row passes then four column passes per block.
module forward_transform_4x4 #(
  parameter int DATA_W = 9,
  parameter int OUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*DATA_W-1:0]  in_block,
  input  logic [3:0]            in_blk_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*OUT_W-1:0]   out_coeff,
  output logic [3:0]            out_blk_idx,
  output logic                  busy
);
  localparam int MID_W = DATA_W + 3;

  typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [3:0]                idx_q;
  logic signed [DATA_W-1:0]  x_q [16];
  logic signed [MID_W-1:0]   t_q [16];
  logic signed [OUT_W-1:0]   y_q [16];

  logic signed [OUT_W-1:0]   bx [4];
  logic signed [OUT_W-1:0]   by [4];
  logic signed [OUT_W-1:0]   s0, s1, d0, d1;

  // Butterfly operand select: a row of the input block, or a column of the intermediate.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bx[i] = '0;
      if (state_q == COL) bx[i] = OUT_W'(t_q[{2'(i), cnt_q}]);
      else                bx[i] = OUT_W'(x_q[{cnt_q, 2'(i)}]);
    end
    s0 = bx[0] + bx[3];
    s1 = bx[1] + bx[2];
    d0 = bx[0] - bx[3];
    d1 = bx[1] - bx[2];
    by[0] = s0 + s1;
    by[1] = d0 + d0 + d1;
    by[2] = s0 - s1;
    by[3] = d0 - d1 - d1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = ROW;
        cnt_d   = 2'd0;
      end
      ROW: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = COL;
      end
      COL: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = OUT;
      end
      OUT: begin
        // One settle cycle after the last column gives the fixed 9-cycle latency.
        if (!out_valid_q) out_valid_d = 1'b1;
        else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      idx_q       <= 4'd0;
      for (int k = 0; k < 16; k++) begin
        x_q[k] <= '0;
        t_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      if (state_q == IDLE && in_valid) begin
        idx_q <= in_blk_idx;
        for (int k = 0; k < 16; k++) x_q[k] <= in_block[k*DATA_W +: DATA_W];
      end
      if (state_q == ROW) begin
        for (int i = 0; i < 4; i++) t_q[{cnt_q, 2'(i)}] <= MID_W'(by[i]);
      end
      if (state_q == COL) begin
        for (int i = 0; i < 4; i++) y_q[{2'(i), cnt_q}] <= by[i];
      end
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_out
    assign out_coeff[gi*OUT_W +: OUT_W] = y_q[gi];
  end

  assign in_ready    = (state_q == IDLE) && rst_n;
  assign out_valid   = out_valid_q;
  assign out_blk_idx = idx_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_forward_transform_4x4.sv
// Directed bench for forward_transform_4x4: known blocks with hand-derived coefficients,
// latency, backpressure, streaming order and mid-block reset.
module tb_forward_transform_4x4;
  localparam int DATA_W = 9;
  localparam int OUT_W  = 16;

  typedef int blk_t [16];

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [16*DATA_W-1:0] in_block = '0;
  logic [3:0]           in_blk_idx = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [16*OUT_W-1:0]  out_coeff;
  logic [3:0]           out_blk_idx;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  logic [16*OUT_W-1:0] got_coeff;
  logic [3:0]          got_idx;

  forward_transform_4x4 #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_blk_idx(in_blk_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
    .out_blk_idx(out_blk_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int coeff_at(input logic [16*OUT_W-1:0] c, input int k);
    logic signed [OUT_W-1:0] v;
    v = c[k*OUT_W +: OUT_W];
    return int'(v);
  endfunction

  function automatic logic [16*DATA_W-1:0] pack(input blk_t x);
    logic [16*DATA_W-1:0] b;
    logic [31:0] w;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      w = x[k];
      b[k*DATA_W +: DATA_W] = w[DATA_W-1:0];
    end
    return b;
  endfunction

  task automatic check_block(input string tag, input blk_t exp);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_Y%0d%0d", tag, k / 4, k % 4), coeff_at(got_coeff, k), exp[k]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic accept_block(input blk_t x, input logic [3:0] idx);
    int n;
    in_block   = pack(x);
    in_blk_idx = idx;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_block   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    in_blk_idx = 4'($urandom());
  endtask

  task automatic run_block(input blk_t x, input logic [3:0] idx, input int hold, input logic early);
    int lat;
    accept_block(x, idx);
    chk("in_ready_low_after_accept", int'(in_ready), 0);
    out_ready = early;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", lat, 9);
    got_coeff = out_coeff;
    got_idx   = out_blk_idx;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_coeff_stable", int'(out_coeff == got_coeff), 1);
      chk("hold_idx", int'(out_blk_idx), int'(idx));
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_falls", int'(out_valid), 0);
    chk("in_ready_after_hs", int'(in_ready), 1);
    chk("out_idx", int'(got_idx), int'(idx));
    $display("block idx=%0d latency=%0d Y00=%0d", got_idx, lat, coeff_at(got_coeff, 0));
  endtask

  blk_t x, e;
  int s [4];

  initial begin
    // Reset state while rst_n is low
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_idx", int'(out_blk_idx), 0);
    chk("rst_coeff_zero", int'(out_coeff == '0), 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // Zero block
    x = '{default: 0}; e = '{default: 0};
    run_block(x, 4'd3, 0, 1'b0);
    check_block("zero", e);

    // Constant +1 and +255 blocks
    x = '{default: 1}; e = '{default: 0}; e[0] = 16;
    run_block(x, 4'd5, 0, 1'b0);
    check_block("ones", e);
    x = '{default: 255}; e = '{default: 0}; e[0] = 4080;
    run_block(x, 4'd6, 0, 1'b1);
    check_block("max", e);

    // Impulse at X[0][0]
    x = '{default: 0}; x[0] = 1;
    e = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
    run_block(x, 4'd9, 0, 1'b0);
    check_block("impulse", e);

    // Sign pattern with 5 cycles of output backpressure
    s = '{1, 1, -1, -1};
    for (int k = 0; k < 16; k++) x[k] = 255 * s[k / 4] * s[k % 4];
    e = '{default: 0}; e[5] = 9180; e[7] = -3060; e[13] = -3060; e[15] = 1020;
    run_block(x, 4'd12, 5, 1'b0);
    check_block("sign", e);

    // Back-to-back stream of 16 constant blocks, value idx-8
    for (int b = 0; b < 16; b++) begin
      x = '{default: b - 8};
      run_block(x, 4'(b), 0, 1'(b % 2));
      chk($sformatf("stream%0d_Y00", b), coeff_at(got_coeff, 0), 16 * (b - 8));
      chk($sformatf("stream%0d_Y12", b), coeff_at(got_coeff, 6), 0);
    end

    // Reset during ROW with cnt=2 aborts the block
    x = '{default: 0}; x[0] = 1;
    accept_block(x, 4'd11);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_coeff_zero", int'(out_coeff == '0), 1);
    chk("abort_idx", int'(out_blk_idx), 0);
    #20 rst_n = 1'b1;
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) chk("aborted_block_output", 1, 0);
    end
    chk("release_out_valid", int'(out_valid), 0);
    e = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
    run_block(x, 4'd2, 0, 1'b0);
    check_block("post_rst", e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
